// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared state encodings and simulation defaults for the
//            push-button conditioning path.
// Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // Debounce FSM state encodings
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Short timing values that keep simulation runs small
  localparam int SIM_DEBOUNCE = 4;
  localparam int SIM_HOLD     = 20;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchronizer for asynchronous board inputs.
//            Asynchronous active-low reset clears both stages to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  // Two back-to-back flops; only q is safe to use in the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronizes and debounces one raw push-button pin, producing a
//            clean level, one-cycle press/release strobes and a long-press
//            (hold) strobe plus a hold-active flag.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic hold_active
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // hold_cnt reaches HOLD_CYCLES-1 on the same edge that fires hold_pulse,
  // so the trigger compares against the value one below that.
  localparam logic [CNT_W-1:0] HOLD_HIT = CNT_W'(HOLD_CYCLES - 2);

  logic             s2;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] deb_cnt_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic             press_accept;
  logic             release_accept;
  logic             hold_hit;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s2)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and acceptance events
  always_comb begin
    state_next     = state;
    press_accept   = 1'b0;
    release_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s2) state_next = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!s2) begin
          state_next = ST_IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = ST_PRESSED;
          press_accept = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!s2) state_next = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (s2) begin
          state_next = ST_PRESSED;
        end else if (deb_cnt == DEB_LAST) begin
          state_next     = ST_IDLE;
          release_accept = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter next values and hold trigger; hold time only accrues in PRESSED
  always_comb begin
    hold_hit = (state == ST_PRESSED) && !hold_active && (hold_cnt == HOLD_HIT);

    if (state_next != state) begin
      deb_cnt_next = '0;
    end else if ((state == ST_PRESS_WAIT) || (state == ST_RELEASE_WAIT)) begin
      deb_cnt_next = deb_cnt + CNT_ONE;
    end else begin
      deb_cnt_next = deb_cnt;
    end

    if (press_accept) begin
      hold_cnt_next = '0;
    end else if ((state == ST_PRESSED) && !hold_active) begin
      hold_cnt_next = hold_cnt + CNT_ONE;
    end else begin
      hold_cnt_next = hold_cnt;
    end
  end

  // Registered counters and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      hold_active   <= 1'b0;
    end else begin
      deb_cnt       <= deb_cnt_next;
      hold_cnt      <= hold_cnt_next;
      press_pulse   <= press_accept;
      release_pulse <= release_accept;
      hold_pulse    <= hold_hit;
      if (press_accept) begin
        btn_level <= 1'b1;
      end else if (release_accept) begin
        btn_level <= 1'b0;
      end
      if (hold_hit) begin
        hold_active <= 1'b1;
      end else if (release_accept) begin
        hold_active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
